// File: rtl/mips_mc_ctrl_if.sv
// Controller <-> datapath bundle for the multicycle MIPS control unit.
// master: the control unit (drives the control word); slave: the datapath.
interface mips_mc_ctrl_if #(
    parameter int unsigned STATE_W = 4
);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               zero;
    logic [3:0]         ALUcontrol;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic               ir_write;
    logic               iord;
    logic               mem_write;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               aluout_we;
    logic               pc_en;
    logic [1:0]         pc_src;
    logic               illegal_op;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, funct, zero,
        output ALUcontrol, alu_src_a, alu_src_b, ir_write, iord, mem_write,
               reg_write, reg_dst, mem_to_reg, aluout_we, pc_en, pc_src,
               illegal_op, state
    );

    modport slave (
        output opcode, funct, zero,
        input  ALUcontrol, alu_src_a, alu_src_b, ir_write, iord, mem_write,
               reg_write, reg_dst, mem_to_reg, aluout_we, pc_en, pc_src,
               illegal_op, state
    );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit feeding an ALU that registers its result.
// Moore control word decoded from the state register; zero only matters in BR_RES.
// Optional macro MC_ILLEGAL_TRAP_EN: illegal decode parks in HALT (state 12)
// with a sticky illegal_op until rst; otherwise illegal_op pulses for the
// decoding cycle and the machine returns to FETCH.
module mips_mc_ctrl (
    input  logic           clk,
    input  logic           rst,
    mips_mc_ctrl_if.master bus
);
    localparam int unsigned STATE_W = 4;
    localparam logic [3:0] ALU_NOP = 4'b1111;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMACC = 4'd3,
        S_MEMWB  = 4'd4,
        S_EXEC   = 4'd5,
        S_EXEC_I = 4'd6,
        S_ALUWB  = 4'd7,
        S_BR_TGT = 4'd8,
        S_BR_CMP = 4'd9,
        S_BR_RES = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

`ifdef MC_ILLEGAL_TRAP_EN
    localparam state_t S_ILL_NEXT = S_HALT;
`else
    localparam state_t S_ILL_NEXT = S_FETCH;
`endif

    state_t     state_q;
    state_t     state_d;
    logic       rdst_q;
    logic       ill_c;
    logic       ill_any;
    logic [3:0] alu_c;
    logic       src_a_c;
    logic [1:0] src_b_c;
    logic       irw_c;
    logic       iord_c;
    logic       memw_c;
    logic       regw_c;
    logic       regdst_c;
    logic       m2r_c;
    logic       aluwe_c;
    logic       pcen_c;
    logic [1:0] pcsrc_c;

    // State register plus the R-type/addi destination flag for ALUWB
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            rdst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rdst_q  <= (state_q == S_EXEC);
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic ill_q;

    // Sticky illegal flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst)        ill_q <= 1'b0;
        else if (ill_c) ill_q <= 1'b1;
    end

    assign ill_any = ill_c | ill_q;
`else
    assign ill_any = ill_c;
`endif

    // Next-state and per-state control word
    always_comb begin
        state_d  = S_FETCH;
        ill_c    = 1'b0;
        alu_c    = ALU_NOP;
        src_a_c  = 1'b0;
        src_b_c  = 2'b00;
        irw_c    = 1'b0;
        iord_c   = 1'b0;
        memw_c   = 1'b0;
        regw_c   = 1'b0;
        regdst_c = 1'b0;
        m2r_c    = 1'b0;
        aluwe_c  = 1'b0;
        pcen_c   = 1'b0;
        pcsrc_c  = 2'b00;
        case (state_q)
            S_FETCH: begin
                irw_c   = 1'b1;
                alu_c   = ALU_ADD;
                src_b_c = 2'b01;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                pcen_c = 1'b1;
                case (bus.opcode)
                    6'b000000: state_d = S_EXEC;
                    6'b001000: state_d = S_EXEC_I;
                    6'b100011,
                    6'b101011: state_d = S_MEMADR;
                    6'b000100: state_d = S_BR_TGT;
                    6'b000010: state_d = S_JUMP;
                    default: begin
                        ill_c   = 1'b1;
                        state_d = S_ILL_NEXT;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_c   = ALU_ADD;
                src_a_c = 1'b1;
                src_b_c = 2'b10;
                state_d = S_MEMACC;
            end
            S_MEMACC: begin
                iord_c = 1'b1;
                if (bus.opcode == 6'b101011) begin
                    memw_c  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                regw_c = 1'b1;
                m2r_c  = 1'b1;
            end
            S_EXEC: begin
                src_a_c = 1'b1;
                state_d = S_ALUWB;
                case (bus.funct)
                    6'b100000: alu_c = ALU_ADD;
                    6'b100010: alu_c = ALU_SUB;
                    6'b100100: alu_c = ALU_AND;
                    6'b100101: alu_c = ALU_OR;
                    6'b101010: alu_c = ALU_SLT;
                    default: begin
                        ill_c   = 1'b1;
                        state_d = S_ILL_NEXT;
                    end
                endcase
            end
            S_EXEC_I: begin
                alu_c   = ALU_ADD;
                src_a_c = 1'b1;
                src_b_c = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regw_c   = 1'b1;
                regdst_c = rdst_q;
            end
            S_BR_TGT: begin
                alu_c   = ALU_ADD;
                src_b_c = 2'b11;
                state_d = S_BR_CMP;
            end
            S_BR_CMP: begin
                aluwe_c = 1'b1;
                alu_c   = ALU_SUB;
                src_a_c = 1'b1;
                state_d = S_BR_RES;
            end
            S_BR_RES: begin
                pcsrc_c = 2'b01;
                pcen_c  = bus.zero;
            end
            S_JUMP: begin
                pcen_c  = 1'b1;
                pcsrc_c = 2'b10;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_HALT: begin
                ill_c   = 1'b1;
                state_d = S_HALT;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Reset forces an inactive control word and a zero debug state
    always_comb begin
        bus.ALUcontrol = rst ? ALU_NOP : alu_c;
        bus.alu_src_a  = src_a_c  & ~rst;
        bus.alu_src_b  = rst ? 2'b00 : src_b_c;
        bus.ir_write   = irw_c    & ~rst;
        bus.iord       = iord_c   & ~rst;
        bus.mem_write  = memw_c   & ~rst;
        bus.reg_write  = regw_c   & ~rst;
        bus.reg_dst    = regdst_c & ~rst;
        bus.mem_to_reg = m2r_c    & ~rst;
        bus.aluout_we  = aluwe_c  & ~rst;
        bus.pc_en      = pcen_c   & ~rst;
        bus.pc_src     = rst ? 2'b00 : pcsrc_c;
        bus.illegal_op = ill_any  & ~rst;
        bus.state      = rst ? '0 : state_q;
    end
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: directed literal checks followed by
// randomized instruction streams compared each cycle against an
// instruction-level model. Honors MC_ILLEGAL_TRAP_EN when defined.
module tb_mips_mc_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    mips_mc_ctrl_if bus ();

    mips_mc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] alu;
        logic       sa;
        logic [1:0] sb;
        logic       irw;
        logic       iord;
        logic       memw;
        logic       regw;
        logic       regdst;
        logic       m2r;
        logic       aluwe;
        logic       pcen;
        logic [1:0] pcsrc;
        logic       ill;
    } cw_t;

    typedef enum logic [2:0] {
        K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_J, K_ILL_OP, K_ILL_FN
    } kind_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [5:0] rfn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z);
        @(negedge clk);
        rst        = r;
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
        #2;
    endtask

    function automatic logic [6:0] enables();
        return {bus.ir_write, bus.iord, bus.mem_write, bus.reg_write,
                bus.aluout_we, bus.pc_en, bus.illegal_op};
    endfunction

    function automatic cw_t dut_cw();
        cw_t c;
        c.st     = bus.state;
        c.alu    = bus.ALUcontrol;
        c.sa     = bus.alu_src_a;
        c.sb     = bus.alu_src_b;
        c.irw    = bus.ir_write;
        c.iord   = bus.iord;
        c.memw   = bus.mem_write;
        c.regw   = bus.reg_write;
        c.regdst = bus.reg_dst;
        c.m2r    = bus.mem_to_reg;
        c.aluwe  = bus.aluout_we;
        c.pcen   = bus.pc_en;
        c.pcsrc  = bus.pc_src;
        c.ill    = bus.illegal_op;
        return c;
    endfunction

    function automatic cw_t idle_cw(input logic [3:0] st);
        cw_t c = '0;
        c.alu = 4'hF;
        c.st  = st;
        return c;
    endfunction

    function automatic logic [3:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic int seq_len(input kind_t k);
        case (k)
            K_LW, K_BEQ: return 5;
            K_R, K_ADDI, K_SW: return 4;
            K_J, K_ILL_FN: return 3;
            default: return 2;
        endcase
    endfunction

    // Expected control word for cycle 'step' of an instruction of kind k
    function automatic cw_t model(input kind_t k, input int step, input logic z, input logic [5:0] fn);
        cw_t c = idle_cw(4'd0);
        if (step == 0) begin
            c.irw = 1'b1; c.alu = 4'b0010; c.sb = 2'b01;
        end else if (step == 1) begin
            c.st = 4'd1; c.pcen = 1'b1; c.ill = (k == K_ILL_OP);
        end else begin
            case (k)
                K_R: if (step == 2) begin
                    c.st = 4'd5; c.sa = 1'b1; c.alu = r_alu(fn);
                end else begin
                    c.st = 4'd7; c.regw = 1'b1; c.regdst = 1'b1;
                end
                K_ILL_FN: begin
                    c.st = 4'd5; c.sa = 1'b1; c.ill = 1'b1;
                end
                K_ADDI: if (step == 2) begin
                    c.st = 4'd6; c.alu = 4'b0010; c.sa = 1'b1; c.sb = 2'b10;
                end else begin
                    c.st = 4'd7; c.regw = 1'b1;
                end
                K_LW, K_SW: if (step == 2) begin
                    c.st = 4'd2; c.alu = 4'b0010; c.sa = 1'b1; c.sb = 2'b10;
                end else if (step == 3) begin
                    c.st = 4'd3; c.iord = 1'b1; c.memw = (k == K_SW);
                end else begin
                    c.st = 4'd4; c.regw = 1'b1; c.m2r = 1'b1;
                end
                K_BEQ: if (step == 2) begin
                    c.st = 4'd8; c.alu = 4'b0010; c.sb = 2'b11;
                end else if (step == 3) begin
                    c.st = 4'd9; c.aluwe = 1'b1; c.alu = 4'b0110; c.sa = 1'b1;
                end else begin
                    c.st = 4'd10; c.pcsrc = 2'b01; c.pcen = z;
                end
                K_J: begin
                    c.st = 4'd11; c.pcen = 1'b1; c.pcsrc = 2'b10;
                end
                default: ;
            endcase
        end
        return c;
    endfunction

    function automatic bit legal_op(input logic [5:0] op);
        return op inside {6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    endfunction

    function automatic bit legal_fn(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    task automatic pick(output kind_t k, output logic [5:0] op, output logic [5:0] fn);
        k  = kind_t'($urandom_range(0, 7));
        op = 6'b000000;
        fn = 6'($urandom);
        case (k)
            K_R:    fn = rfn[$urandom_range(0, 4)];
            K_ADDI: op = 6'b001000;
            K_LW:   op = 6'b100011;
            K_SW:   op = 6'b101011;
            K_BEQ:  op = 6'b000100;
            K_J:    op = 6'b000010;
            K_ILL_OP: begin
                op = 6'($urandom);
                while (legal_op(op)) op = 6'($urandom);
            end
            K_ILL_FN: while (legal_fn(fn)) fn = 6'($urandom);
            default: ;
        endcase
    endtask

`ifdef MC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    initial begin
        kind_t      k;
        int         step;
        bit         halted;
        int         hcnt;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       r;
        cw_t        exp;

        bus.opcode = 6'd0;
        bus.funct  = 6'd0;
        bus.zero   = 1'b0;

        // Reset held for two cycles
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 6'b000000, 6'b000000, 1'b1);
            chk("rst_state", 32'(bus.state), 32'd0);
            chk("rst_alu", 32'(bus.ALUcontrol), 32'hF);
            chk("rst_enables", 32'(enables()), 32'd0);
        end

        // R-type sub
        drive(1'b0, 6'b000000, 6'b100010, 1'b0);
        chk("fetch_state", 32'(bus.state), 32'd0);
        chk("fetch_irw", 32'(bus.ir_write), 32'd1);
        chk("fetch_alu", 32'(bus.ALUcontrol), 32'h2);
        chk("fetch_srcb", 32'(bus.alu_src_b), 32'd1);
        drive(1'b0, 6'b000000, 6'b100010, 1'b0);
        chk("decode_state", 32'(bus.state), 32'd1);
        chk("decode_pcen", 32'({bus.pc_en, bus.pc_src}), 32'b100);
        drive(1'b0, 6'b000000, 6'b100010, 1'b1);
        chk("exec_state", 32'(bus.state), 32'd5);
        chk("exec_sub", 32'(bus.ALUcontrol), 32'h6);
        chk("exec_src", 32'({bus.alu_src_a, bus.alu_src_b}), 32'b100);
        drive(1'b0, 6'b000000, 6'b100010, 1'b0);
        chk("aluwb_state", 32'(bus.state), 32'd7);
        chk("aluwb_wr", 32'({bus.reg_write, bus.reg_dst, bus.mem_to_reg}), 32'b110);

        // Jump aborted by reset during DECODE
        drive(1'b0, 6'b000010, 6'b000000, 1'b0);
        chk("j_fetch_state", 32'(bus.state), 32'd0);
        drive(1'b1, 6'b000010, 6'b000000, 1'b0);
        chk("j_rst_pcen", 32'(bus.pc_en), 32'd0);
        chk("j_rst_state", 32'(bus.state), 32'd0);

        // Branch taken
        drive(1'b0, 6'b000100, 6'b000000, 1'b0);
        chk("beq_fetch", 32'({bus.state, bus.ir_write}), 32'b00001);
        drive(1'b0, 6'b000100, 6'b000000, 1'b0);
        chk("beq_decode", 32'(bus.state), 32'd1);
        drive(1'b0, 6'b000100, 6'b000000, 1'b0);
        chk("beq_tgt", 32'({bus.state, bus.alu_src_a, bus.alu_src_b, bus.aluout_we}), 32'b1000_0_11_0);
        drive(1'b0, 6'b000100, 6'b000000, 1'b0);
        chk("beq_cmp", 32'({bus.state, bus.ALUcontrol, bus.aluout_we}), 32'b1001_0110_1);
        drive(1'b0, 6'b000100, 6'b000000, 1'b1);
        chk("beq_res", 32'({bus.state, bus.pc_en, bus.pc_src, bus.aluout_we}), 32'b1010_1_01_0);

        // Illegal opcode
        drive(1'b0, 6'b111111, 6'b000000, 1'b0);
        chk("ill_fetch", 32'(bus.state), 32'd0);
        drive(1'b0, 6'b111111, 6'b000000, 1'b0);
        chk("ill_decode", 32'({bus.state, bus.illegal_op}), 32'b0001_1);
`ifdef MC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 6'b111111, 6'b000000, 1'($urandom));
            chk($sformatf("halt_%0d", i), 32'({bus.state, bus.ALUcontrol, enables()}), 32'b1100_1111_0000001);
        end
`else
        drive(1'b0, 6'b111111, 6'b000000, 1'b0);
        chk("ill_after", 32'({bus.state, bus.illegal_op, bus.ir_write}), 32'b0000_0_1);
`endif
        drive(1'b1, 6'b000000, 6'b000000, 1'b0);

        // Randomized instruction stream against the model
        step   = 0;
        halted = 1'b0;
        hcnt   = 0;
        op     = 6'd0;
        fn     = 6'd0;
        k      = K_R;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            z = 1'($urandom);
            r = (halted && hcnt >= 12) || ($urandom_range(0, 39) == 0);
            if (!r && !halted && step == 0) pick(k, op, fn);
            drive(r, op, fn, z);
            if (r) begin
                exp = idle_cw(4'd0);
            end else if (halted) begin
                exp     = idle_cw(4'd12);
                exp.ill = 1'b1;
            end else begin
                exp = model(k, step, z, fn);
            end
            chk($sformatf("cyc%0d_k%0d_s%0d", cyc, k, step), 32'(dut_cw()), 32'(exp));
            if (r) begin
                step   = 0;
                halted = 1'b0;
                hcnt   = 0;
            end else if (halted) begin
                hcnt++;
            end else begin
                step++;
                if (step == seq_len(k)) begin
                    step = 0;
                    if (TRAP && (k == K_ILL_OP || k == K_ILL_FN)) begin
                        halted = 1'b1;
                        hcnt   = 0;
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Multicycle MIPS control unit directly upstream of the ALU. Decodes opcode/funct into a per-state control word: datapath mux selects, write enables and the 4-bit ALUcontrol code the ALU consumes. Accounts for the ALU registering ALUresult/zero on posedge clk, so an op issued in state N is visible to the datapath in state N+1.

Parameters:
ALU_NOP, 4'b1111, ALUcontrol code matching no ALU case; ALU holds ALUresult and zero
STATE_W, 4, state register width

Ports:
clk  in  1  clock, all state changes on posedge
rst  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, updated only on subtract
ALUcontrol  out  4  0000 AND, 0001 OR, 0010 add, 0110 sub, 0111 slt, ALU_NOP otherwise
alu_src_a  out  1  0=PC, 1=reg A
alu_src_b  out  2  00=reg B, 01=const 4, 10=sext imm, 11=sext imm<<2
ir_write  out  1  load IR from memory
iord  out  1  memory address: 0=PC, 1=ALUresult
mem_write  out  1  memory write strobe
reg_write  out  1  register file write
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUresult, 1=MDR
aluout_we  out  1  capture ALUresult into ALUOut
pc_en  out  1  PC write enable
pc_src  out  2  00=ALUresult, 01=ALUOut, 10=jump target
illegal_op  out  1  unsupported opcode/funct
state  out  STATE_W  current state, debug

Behaviour:
- Moore machine; outputs are combinational from state only (zero used only in BR_RES). Non-listed outputs 0, ALUcontrol=ALU_NOP.
- rst high at posedge: state<=FETCH, illegal sticky cleared. While rst is high, all enables forced 0, ALUcontrol=ALU_NOP, state output reads 0. Reset mid-instruction aborts it; no further write enables after the edge.
- FETCH(0): ir_write=1, iord=0, add, src_a=0, src_b=01 -> DECODE.
- DECODE(1): pc_en=1, pc_src=00 (PC<=PC+4). Next: 000000->EXEC; 001000 addi->EXEC_I; 100011/101011->MEMADR; 000100->BR_TGT; 000010->JUMP; else illegal.
- MEMADR(2): add, src_a=1, src_b=10 -> MEMACC.
- MEMACC(3): iord=1; SW: mem_write=1 -> FETCH; LW -> MEMWB.
- MEMWB(4): reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- EXEC(5): src_a=1, src_b=00; funct 100000 add, 100010 sub, 100100 AND, 100101 OR, 101010 slt -> ALUWB; other funct: ALU_NOP, illegal.
- EXEC_I(6): add, src_a=1, src_b=10 -> ALUWB.
- ALUWB(7): reg_write=1, mem_to_reg=0, reg_dst=1 if entered from EXEC, 0 from EXEC_I (1-bit flag register).
- BR_TGT(8): add, src_a=0, src_b=11 (uses updated PC) -> BR_CMP.
- BR_CMP(9): aluout_we=1 (captures target), sub, src_a=1, src_b=00 -> BR_RES.
- BR_RES(10): pc_src=01, pc_en=zero -> FETCH.
- JUMP(11): pc_en=1, pc_src=10 -> FETCH.
- Cycle counts: R/addi 4, LW 5, SW 4, BEQ 5, J 3.
- Unused encodings 12-15 -> FETCH next cycle, outputs inactive.

Optional Feature:
MC_ILLEGAL_TRAP_EN: defined -> illegal decode enters HALT(12): illegal_op=1 sticky, all enables 0, ALU_NOP, held until rst. Undefined -> illegal_op pulses 1 for the decoding cycle only, next state FETCH, no writes issued.

Test Plan:
- rst=1 for 2 cycles -> all enables 0, ALUcontrol=1111, state=0; release -> FETCH with ir_write=1, ALUcontrol=0010, src_b=01.
- opcode 000000 funct 100010 -> FETCH,DECODE,EXEC(ALUcontrol=0110, src_a=1, src_b=00),ALUWB(reg_write=1, reg_dst=1),FETCH.
- opcode 100011 -> 5 states, MEMACC iord=1, MEMWB mem_to_reg=1, reg_dst=0; opcode 101011 -> mem_write=1 exactly one cycle, no reg_write.
- opcode 000100, zero=1 at BR_RES -> pc_en=1, pc_src=01; repeat with zero=0 -> pc_en=0; aluout_we=1 only in BR_CMP.
- opcode 000010 -> 3 cycles, JUMP pc_en=1, pc_src=10; rst asserted during DECODE -> next cycle FETCH, no pc_en pulse.
- opcode 111111 -> macro off: illegal_op 1 cycle, then FETCH; macro on: state=12, illegal_op held 1 for 10+ cycles until rst.
